// File: rtl/dcache_mem_responder.sv
// Word-beat memory responder for the data cache: serves reads and write-back writes
// from an on-chip word RAM with configurable latency and write-burst framing checks.
module dcache_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        wlast,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [31:0] mem_rdata,
  output logic        burst_err
);

  localparam int             DEPTH     = 1 << DEPTH_LOG2;
  localparam int             WCW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [3:0]     LAT       = 4'(LATENCY);
  localparam logic [WCW-1:0] WLAST_IDX = WCW'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_wen;
  logic [31:0]           r_wdata;
  logic [WCW-1:0]        r_wcnt;
  logic                  r_burst_err;
  logic [31:0]           r_rdata;
  logic [31:0]           r_ram [DEPTH];

  logic [DEPTH_LOG2-1:0] w_addr_idx;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_rd_wen;
  logic                  w_load_rd;
  logic                  w_unused;

  // Byte-offset and upper address bits alias by design.
  assign w_addr_idx = mem_addr[DEPTH_LOG2+1:2];
  assign w_unused   = &{1'b0, mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    mem_addr_ok  = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_addr_ok = mem_req & reset;
        if (mem_req && reset) begin
          w_cnt_next   = LAT;
          w_state_next = (LAT == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // With zero latency the RAM is read straight from the accept-cycle address.
  assign w_rd_idx  = (r_state == S_IDLE) ? w_addr_idx : r_idx;
  assign w_rd_wen  = (r_state == S_IDLE) ? mem_wen : r_wen;
  assign w_load_rd = (w_state_next == S_RESP) && (r_state != S_RESP) && !w_rd_wen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= 32'd0;
      r_wcnt      <= '0;
      r_burst_err <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (mem_addr_ok) begin
        r_idx   <= w_addr_idx;
        r_wen   <= mem_wen;
        r_wdata <= mem_wdata;
        if (mem_wen) begin
          if (wlast) begin
            if (r_wcnt != WLAST_IDX) r_burst_err <= 1'b1;
            r_wcnt <= '0;
          end else if (r_wcnt == WLAST_IDX) begin
            r_burst_err <= 1'b1;
            r_wcnt      <= '0;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end else if (r_wcnt != '0) begin
          r_burst_err <= 1'b1;
        end
      end
      if (w_load_rd) begin
        r_rdata <= r_ram[w_rd_idx];
      end
    end
  end

  // Commit happens on the edge leaving RESP; a reset before that edge drops the write.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_wen) begin
      r_ram[r_idx] <= r_wdata;
    end
  end

  assign mem_data_ok = (r_state == S_RESP);
  assign mem_rdata   = r_rdata;
  assign burst_err   = r_burst_err;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Scoreboard bench for dcache_mem_responder: LATENCY=2 instance with a queue-based
// monitor, plus a LATENCY=0 instance for the back-to-back alternation pattern.
module tb_dcache_mem_responder;

  localparam int LAT = 2;

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req = 1'b0, mem_wen = 1'b0, wlast = 1'b0;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
  logic        mem_addr_ok, mem_data_ok, burst_err;
  logic [31:0] mem_rdata;

  logic        d0_req = 1'b0, d0_wen = 1'b0, d0_wlast = 1'b0;
  logic [31:0] d0_addr = 32'd0, d0_wdata = 32'd0;
  logic        d0_addr_ok, d0_data_ok, d0_berr;
  logic [31:0] d0_rdata;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  exp_t mon_e;
  int   mon_a;

  dcache_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT), .BURST_LEN(8)) u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wlast(wlast),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .burst_err(burst_err)
  );

  dcache_mem_responder #(.DEPTH_LOG2(10), .LATENCY(0), .BURST_LEN(8)) u_dut0 (
    .clk(clk), .reset(reset), .mem_req(d0_req), .mem_wen(d0_wen),
    .mem_addr(d0_addr), .mem_wdata(d0_wdata), .wlast(d0_wlast),
    .mem_addr_ok(d0_addr_ok), .mem_data_ok(d0_data_ok),
    .mem_rdata(d0_rdata), .burst_err(d0_berr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every data_ok pops one expectation and one accept timestamp.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_addr_ok) acc_q.push_back(cyc);
      if (mem_data_ok) begin
        chk("no_overlap", {31'd0, mem_addr_ok}, 32'd0);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_data_ok: got data_ok=1 expected no response (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          chk("latency", 32'(cyc - mon_a), 32'(LAT + 1));
          if (mon_e.rd) chk("rdata", mem_rdata, mon_e.data);
          $display("resp %s rdata=0x%08h cycle=%0d", mon_e.rd ? "RD" : "WR", mem_rdata, cyc);
        end
      end
    end
  end

  // Issue one beat; returns 1 time unit after the accepting edge.
  task automatic beat(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                      input logic wl, input logic [31:0] expd);
    int n;
    exp_t e;
    n = 0;
    mem_req = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wd; wlast = wl;
    @(negedge clk);
    while (!mem_addr_ok && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!mem_addr_ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no addr_ok expected accept of 0x%08h", addr);
    end else begin
      e.rd = ~wen;
      e.data = expd;
      exp_q.push_back(e);
      $display("beat %s addr=0x%08h wdata=0x%08h wlast=%0b", wen ? "WR" : "RD", addr, wd, wl);
    end
    @(posedge clk);
    #1;
    // Scramble inputs to show they are only sampled at acceptance.
    mem_req = 1'b0; mem_addr = 32'hFFFF_FFFC; mem_wdata = 32'h0BAD_0BAD; wlast = ~wl;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_req = 1'b1;
    #1;
    chk("rst_addr_ok", {31'd0, mem_addr_ok}, 32'd0);
    chk("rst_data_ok", {31'd0, mem_data_ok}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_burst_err", {31'd0, burst_err}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_data_ok", {31'd0, mem_data_ok}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    do_reset();

    // Legal 8-beat write burst, then read back word 3.
    for (int i = 0; i < 8; i++)
      beat(1'b1, 32'h100 + 32'(4 * i), 32'h11 * 32'(i + 1), (i == 7), 32'd0);
    beat(1'b0, 32'h10C, 32'd0, 1'b0, 32'h44);
    for (int i = 0; i < 8; i++)
      beat(1'b1, 32'h40 + 32'(4 * i), (i == 0) ? 32'hAAAA_5555 : 32'hA0 + 32'(i), (i == 7), 32'd0);
    for (int i = 0; i < 8; i++)
      beat(1'b1, 32'h1000 + 32'(4 * i), (i == 1) ? 32'hDEAD_BEEF : 32'h100 + 32'(i), (i == 7), 32'd0);
    beat(1'b0, 32'h0000_0006, 32'd0, 1'b0, 32'hDEAD_BEEF);
    beat(1'b0, 32'h40, 32'd0, 1'b0, 32'hAAAA_5555);
    drain();
    chk("legal_burst_err", {31'd0, burst_err}, 32'd0);

    // Lone write with wlast (early last), reset while it waits.
    beat(1'b1, 32'h40, 32'h1234_5678, 1'b1, 32'd0);
    chk("lone_wlast_err", {31'd0, burst_err}, 32'd1);
    do_reset();
    beat(1'b0, 32'h40, 32'd0, 1'b0, 32'hAAAA_5555);
    drain();

    // Early wlast on beat 3, then a legal burst: flag stays sticky.
    beat(1'b1, 32'h300, 32'h2000, 1'b0, 32'd0);
    beat(1'b1, 32'h304, 32'h2001, 1'b0, 32'd0);
    chk("early_before", {31'd0, burst_err}, 32'd0);
    beat(1'b1, 32'h308, 32'h2002, 1'b1, 32'd0);
    chk("early_after", {31'd0, burst_err}, 32'd1);
    for (int i = 0; i < 8; i++)
      beat(1'b1, 32'h300 + 32'(4 * i), 32'h3000 + 32'(i), (i == 7), 32'd0);
    beat(1'b0, 32'h304, 32'd0, 1'b0, 32'h3001);
    drain();
    chk("early_sticky", {31'd0, burst_err}, 32'd1);

    // Missing wlast.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 32'h380 + 32'(4 * i), 32'h4000 + 32'(i), 1'b0, 32'd0);
      if (i == 6) chk("missing_before", {31'd0, burst_err}, 32'd0);
    end
    chk("missing_after", {31'd0, burst_err}, 32'd1);
    drain();

    // Read interleaved into an unfinished write burst.
    do_reset();
    beat(1'b1, 32'h3C0, 32'h5A5A_0000, 1'b0, 32'd0);
    beat(1'b1, 32'h3C4, 32'h5A5A_0001, 1'b0, 32'd0);
    chk("interleave_before", {31'd0, burst_err}, 32'd0);
    beat(1'b0, 32'h3C0, 32'd0, 1'b0, 32'h5A5A_0000);
    chk("interleave_after", {31'd0, burst_err}, 32'd1);
    drain();

    // LATENCY=0 instance: preload, then four reads with mem_req held high.
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      d0_req = 1'b1; d0_wen = 1'b1; d0_addr = 32'h200 + 32'(4 * i); d0_wdata = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      while (!d0_addr_ok && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("l0_wr_accept", {31'd0, d0_addr_ok}, 32'd1);
      @(posedge clk);
      #1;
      d0_req = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    d0_req = 1'b1; d0_wen = 1'b0; d0_addr = 32'h200;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("l0_addr_ok", {31'd0, d0_addr_ok}, ((k % 2) == 0) ? 32'd1 : 32'd0);
      chk("l0_data_ok", {31'd0, d0_data_ok}, ((k % 2) == 1) ? 32'd1 : 32'd0);
      if ((k % 2) == 1) begin
        chk("l0_rdata", d0_rdata, 32'hC0DE_0000 + 32'(k / 2));
        $display("l0 resp rdata=0x%08h cycle=%0d", d0_rdata, cyc);
      end
      @(posedge clk);
      #1;
      if ((k % 2) == 0) d0_addr = 32'h200 + 32'(4 * (k / 2 + 1));
      if (k == 7) d0_req = 1'b0;
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
